// File: rtl/clink_pixel_packer_if.sv
// ---------------------------------------------------------------------------
// clink_pixel_packer_if
//   Word stream from the pixel packer into the write side of the CDC FIFO.
//   Signals:
//     out_data   packed DRAM word, first pixel in the LSBs
//     out_valid  a word is presented
//     out_ready  consumer (~fifo_full) accepts the presented word
//     out_last   presented word is a line-end flush word
//   Modports:
//     master  packer side (drives data/valid/last, samples ready)
//     slave   FIFO side   (samples data/valid/last, drives ready)
// ---------------------------------------------------------------------------
interface clink_pixel_packer_if #(
  parameter int DRAM_DATA_WIDTH = 512
);
  logic [DRAM_DATA_WIDTH-1:0] out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       out_last;

  modport master (output out_data, output out_valid, output out_last, input out_ready);
  modport slave  (input out_data, input out_valid, input out_last, output out_ready);
endinterface

// File: rtl/clink_pixel_packer.sv
// ---------------------------------------------------------------------------
// clink_pixel_packer
//   Packs Camera Link pixels (TAPS x TAP_WIDTH bits per pixel clock) into
//   DRAM_DATA_WIDTH-bit words. Pixels occupy SLOT bits each, either tightly
//   (SLOT = TAPS*TAP_WIDTH) or padded to the next power of two. A pixel that
//   straddles a word boundary is split: the low part completes the current
//   word, the high part is carried into the next. At line end any partial
//   word is zero-padded and flushed with out_last set.
//   Ports:
//     clink_X_clk       pixel clock (only clock)
//     clk_pixel_resetn  asynchronous active-low reset
//     pixel_data        tap k at [k*TAP_WIDTH +: TAP_WIDTH]
//     fval/lval/dval    frame / line / data valid
//     capture_en        arms capture; sampled only at frame start
//     out_if            word stream (valid/ready) to the CDC FIFO
//     frame_count       number of captured frames, wraps
//     overflow          sticky: a word was dropped under back-pressure
// ---------------------------------------------------------------------------
module clink_pixel_packer #(
  parameter int DRAM_DATA_WIDTH = 512,
  parameter int TAPS            = 3,
  parameter int TAP_WIDTH       = 8,
  parameter int PAD_PIXELS      = 0,
  parameter int FRAME_CNT_WIDTH = 8
) (
  input  logic                       clink_X_clk,
  input  logic                       clk_pixel_resetn,
  input  logic [TAPS*TAP_WIDTH-1:0]  pixel_data,
  input  logic                       fval,
  input  logic                       lval,
  input  logic                       dval,
  input  logic                       capture_en,
  clink_pixel_packer_if.master       out_if,
  output logic [FRAME_CNT_WIDTH-1:0] frame_count,
  output logic                       overflow
);

  localparam int PIX_W  = TAPS * TAP_WIDTH;
  localparam int SLOT   = (PAD_PIXELS != 0) ? (1 << $clog2(PIX_W)) : PIX_W;
  // Accumulator holds one unfinished word plus the pixel that may overrun it.
  localparam int ACC_W  = DRAM_DATA_WIDTH + SLOT;
  localparam int FILL_W = $clog2(ACC_W + 1);

  localparam logic [FILL_W-1:0] SLOT_F = FILL_W'(SLOT);
  localparam logic [FILL_W-1:0] DRAM_F = FILL_W'(DRAM_DATA_WIDTH);

  // Packing state
  logic [ACC_W-1:0]           acc_q,   acc_d;
  logic [FILL_W-1:0]          fill_q,  fill_d;
  logic                       armed_q, armed_d;
  logic                       fval_q,  lval_q;

  // Output register and status
  logic [DRAM_DATA_WIDTH-1:0] data_q,  data_d;
  logic                       valid_q, valid_d;
  logic                       last_q,  last_d;
  logic [FRAME_CNT_WIDTH-1:0] frame_q, frame_d;
  logic                       ovf_q,   ovf_d;

  // Edge detects against the previous-cycle frame/line valid.
  logic fval_rise, fval_fall, lval_fall;
  logic accept, flush;
  assign fval_rise = fval & ~fval_q;
  assign fval_fall = ~fval & fval_q;
  assign lval_fall = ~lval & lval_q;
  assign accept    = armed_q & fval & lval & dval;
  assign flush     = armed_q & lval_fall & (fill_q != '0);

  // Accumulator with the incoming pixel inserted above the current fill.
  // Bits above fill_q are always zero, so OR-ing is a plain insert.
  logic [ACC_W-1:0]  acc_ins;
  logic [FILL_W-1:0] fill_sum;
  assign acc_ins  = acc_q | (ACC_W'(pixel_data) << fill_q);
  assign fill_sum = fill_q + SLOT_F;

  logic                       load;
  logic [DRAM_DATA_WIDTH-1:0] word;
  logic                       word_last;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latches).
    acc_d     = acc_q;
    fill_d    = fill_q;
    armed_d   = armed_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    frame_d   = frame_q;
    ovf_d     = ovf_q;
    load      = 1'b0;
    word      = acc_ins[DRAM_DATA_WIDTH-1:0];
    word_last = 1'b0;

    // capture_en only matters at frame start; mid-frame changes are ignored.
    if (fval_rise) armed_d = capture_en;

    if (fval_fall && armed_q) frame_d = frame_q + 1'b1;

    if (fval_rise) begin
      // Discard anything left over from an unflushed previous frame.
      acc_d  = '0;
      fill_d = '0;
    end else if (accept) begin
      if (fill_sum >= DRAM_F) begin
        load   = 1'b1;
        word   = acc_ins[DRAM_DATA_WIDTH-1:0];
        acc_d  = acc_ins >> DRAM_DATA_WIDTH;
        fill_d = fill_sum - DRAM_F;
      end else begin
        acc_d  = acc_ins;
        fill_d = fill_sum;
      end
    end else if (flush) begin
      // fill_q < DRAM_DATA_WIDTH here, so the low word already carries the zero pad.
      load      = 1'b1;
      word      = acc_q[DRAM_DATA_WIDTH-1:0];
      word_last = 1'b1;
      acc_d     = '0;
      fill_d    = '0;
    end

    // Output register: a held word is never overwritten; a colliding new word
    // is dropped and flagged, while the carry bits above stay in acc_d.
    if (load) begin
      if (valid_q && !out_if.out_ready) begin
        ovf_d = 1'b1;
      end else begin
        data_d  = word;
        last_d  = word_last;
        valid_d = 1'b1;
      end
    end else if (valid_q && out_if.out_ready) begin
      valid_d = 1'b0;
    end
  end

  // NOTE: the accumulator is a flat register, not a memory array, so it is reset along with all other state.
  always_ff @(posedge clink_X_clk or negedge clk_pixel_resetn) begin
    if (!clk_pixel_resetn) begin
      acc_q   <= '0;
      fill_q  <= '0;
      armed_q <= 1'b0;
      fval_q  <= 1'b0;
      lval_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      frame_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      acc_q   <= acc_d;
      fill_q  <= fill_d;
      armed_q <= armed_d;
      fval_q  <= fval;
      lval_q  <= lval;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      frame_q <= frame_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_if.out_data  = data_q;
  assign out_if.out_valid = valid_q;
  assign out_if.out_last  = last_q;
  assign frame_count      = frame_q;
  assign overflow         = ovf_q;

endmodule

// File: tb/tb_clink_pixel_packer.sv
// ---------------------------------------------------------------------------
// tb_clink_pixel_packer
//   Directed bench for clink_pixel_packer. Two instances share clock, reset
//   and the pixel/frame/line inputs: a tight-packed one (24-bit slots) and a
//   padded one (32-bit slots), each with its own capture_en so only one is
//   active at a time. Transferred words are recorded at the falling edge.
// ---------------------------------------------------------------------------
module tb_clink_pixel_packer;

  localparam int DW = 512;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  logic        clk;
  logic        rst_n;
  logic [23:0] pixel_data;
  logic        fval, lval, dval;
  logic        capture_en, capture_en_p;
  logic [7:0]  frame_count, frame_count_p;
  logic        overflow, overflow_p;

  int n_checks = 0;
  int n_fail   = 0;

  word_t main_q[$];
  word_t pad_q[$];

  clink_pixel_packer_if #(.DRAM_DATA_WIDTH(DW)) bus   ();
  clink_pixel_packer_if #(.DRAM_DATA_WIDTH(DW)) bus_p ();

  clink_pixel_packer #(
    .DRAM_DATA_WIDTH(DW), .TAPS(3), .TAP_WIDTH(8), .PAD_PIXELS(0), .FRAME_CNT_WIDTH(8)
  ) dut (
    .clink_X_clk(clk), .clk_pixel_resetn(rst_n), .pixel_data(pixel_data),
    .fval(fval), .lval(lval), .dval(dval), .capture_en(capture_en),
    .out_if(bus.master), .frame_count(frame_count), .overflow(overflow)
  );

  clink_pixel_packer #(
    .DRAM_DATA_WIDTH(DW), .TAPS(3), .TAP_WIDTH(8), .PAD_PIXELS(1), .FRAME_CNT_WIDTH(8)
  ) dut_pad (
    .clink_X_clk(clk), .clk_pixel_resetn(rst_n), .pixel_data(pixel_data),
    .fval(fval), .lval(lval), .dval(dval), .capture_en(capture_en_p),
    .out_if(bus_p.master), .frame_count(frame_count_p), .overflow(overflow_p)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every accepted word, sampled mid-cycle.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready)     main_q.push_back({bus.out_data, bus.out_last});
    if (bus_p.out_valid && bus_p.out_ready) pad_q.push_back({bus_p.out_data, bus_p.out_last});
  end

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_word(input string tag, input bit from_pad, input int idx,
                            input logic [DW-1:0] exp_data, input logic exp_last);
    int    sz;
    word_t w;
    sz = from_pad ? pad_q.size() : main_q.size();
    check($sformatf("%s_present", tag), DW'(idx < sz), DW'(1));
    if (idx < sz) begin
      w = from_pad ? pad_q[idx] : main_q[idx];
      check($sformatf("%s_data", tag), w.data, exp_data);
      check($sformatf("%s_last", tag), DW'(w.last), DW'(exp_last));
    end
  endtask

  // Byte stream k = k mod 256, starting at byte first.
  function automatic logic [DW-1:0] ramp_word(input int first, input int nbytes);
    logic [DW-1:0] w;
    w = '0;
    for (int b = 0; b < nbytes; b++) w[b*8 +: 8] = 8'(first + b);
    return w;
  endfunction

  function automatic logic [23:0] ramp_pixel(input int i);
    return {8'(3*i + 2), 8'(3*i + 1), 8'(3*i)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  task automatic start_frame(input logic cap, input logic cap_p);
    capture_en   = cap;
    capture_en_p = cap_p;
    fval = 1'b1; lval = 1'b0; dval = 1'b0;
    idle(2);
  endtask

  task automatic send_pixels(input int first, input int n);
    lval = 1'b1;
    for (int i = 0; i < n; i++) begin
      pixel_data = ramp_pixel(first + i);
      dval = 1'b1;
      tick();
    end
    dval = 1'b0;
  endtask

  task automatic end_line();
    lval = 1'b0; dval = 1'b0;
    idle(3);
  endtask

  task automatic end_frame();
    fval = 1'b0;
    idle(3);
  endtask

  logic [DW-1:0] exp_w;
  logic [DW-1:0] pad_or;

  initial begin
    rst_n = 1'b0; pixel_data = '0; fval = 0; lval = 0; dval = 0;
    capture_en = 0; capture_en_p = 0;
    bus.out_ready = 1'b1; bus_p.out_ready = 1'b1;
    idle(2);

    // ---- reset state (held in reset) ----
    check("rst_valid",   DW'(bus.out_valid), '0);
    check("rst_data",    bus.out_data, '0);
    check("rst_last",    DW'(bus.out_last), '0);
    check("rst_frame",   DW'(frame_count), '0);
    check("rst_ovf",     DW'(overflow), '0);
    rst_n = 1'b1;
    idle(1);

    // ---- 1: 64 tight pixels -> 3 ramp words, no flush ----
    start_frame(1, 0);
    send_pixels(0, 64);
    idle(2);
    check("t1_count", DW'(main_q.size()), DW'(3));
    check_word("t1_w0", 0, 0, ramp_word(0, 64),   1'b0);
    check_word("t1_w1", 0, 1, ramp_word(64, 64),  1'b0);
    check_word("t1_w2", 0, 2, ramp_word(128, 64), 1'b0);
    end_line();
    check("t1_no_flush", DW'(main_q.size()), DW'(3));

    // ---- 3: 10-pixel line -> one zero-padded flush word ----
    main_q.delete();
    send_pixels(0, 10);
    end_line();
    check("t3_count", DW'(main_q.size()), DW'(1));
    check_word("t3_flush", 0, 0, ramp_word(0, 30), 1'b1);
    end_frame();
    check("t3_frame_count", DW'(frame_count), DW'(1));
    check("t3_ovf", DW'(overflow), '0);

    // ---- 2: padded slots, 16 pixels -> 1 word, 17th flushed ----
    start_frame(0, 1);
    send_pixels(0, 17);
    end_line();
    exp_w = '0;
    for (int j = 0; j < 16; j++) exp_w[j*32 +: 32] = {8'h00, ramp_pixel(j)};
    check("t2_count", DW'(pad_q.size()), DW'(2));
    check_word("t2_w0", 1, 0, exp_w, 1'b0);
    pad_or = '0;
    if (pad_q.size() > 0)
      for (int j = 0; j < 16; j++) pad_or[7:0] = pad_or[7:0] | pad_q[0].data[j*32+24 +: 8];
    check("t2_pad_bytes", pad_or, '0);
    check_word("t2_flush", 1, 1, DW'({8'h00, 8'd50, 8'd49, 8'd48}), 1'b1);
    check("t2_main_idle", DW'(main_q.size()), DW'(1));
    end_frame();
    capture_en_p = 1'b0;

    // ---- 4: back-pressure across two completions ----
    do_reset();
    main_q.delete();
    bus.out_ready = 1'b0;
    start_frame(1, 0);
    send_pixels(0, 43);
    check("t4_valid_held", DW'(bus.out_valid), DW'(1));
    check("t4_data_held",  bus.out_data, ramp_word(0, 64));
    check("t4_ovf",        DW'(overflow), DW'(1));
    idle(3);
    check("t4_data_stable", bus.out_data, ramp_word(0, 64));
    bus.out_ready = 1'b1;
    idle(2);
    send_pixels(43, 21);
    end_line();
    check("t4_count", DW'(main_q.size()), DW'(2));
    check_word("t4_w0", 0, 0, ramp_word(0, 64),   1'b0);
    check_word("t4_w1", 0, 1, ramp_word(128, 64), 1'b0);
    check("t4_ovf_sticky", DW'(overflow), DW'(1));
    end_frame();

    // ---- 5: capture_en low at frame start, then armed next frame ----
    do_reset();
    main_q.delete();
    start_frame(0, 0);
    capture_en = 1'b1;
    send_pixels(0, 64);
    end_line();
    end_frame();
    check("t5_no_words", DW'(main_q.size()), '0);
    check("t5_frame_unchanged", DW'(frame_count), '0);
    start_frame(1, 0);
    send_pixels(0, 64);
    end_line();
    end_frame();
    check("t5_count", DW'(main_q.size()), DW'(3));
    check_word("t5_w0", 0, 0, ramp_word(0, 64), 1'b0);
    check("t5_frame_count", DW'(frame_count), DW'(1));

    // ---- 6: reset mid-word with a held output word ----
    main_q.delete();
    bus.out_ready = 1'b0;
    start_frame(1, 0);
    send_pixels(0, 10);
    end_line();
    send_pixels(10, 10);
    check("t6_pre_valid", DW'(bus.out_valid), DW'(1));
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", DW'(bus.out_valid), '0);
    check("t6_rst_data",  bus.out_data, '0);
    check("t6_rst_last",  DW'(bus.out_last), '0);
    check("t6_rst_frame", DW'(frame_count), '0);
    check("t6_rst_ovf",   DW'(overflow), '0);
    fval = 1'b0; lval = 1'b0; dval = 1'b0;
    idle(2);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    idle(1);
    main_q.delete();
    start_frame(1, 0);
    lval = 1'b1;
    for (int i = 0; i < 22; i++) begin
      pixel_data = 24'h5A5A5A;
      dval = 1'b1;
      tick();
    end
    dval = 1'b0;
    end_line();
    check("t6_count", DW'(main_q.size()), DW'(2));
    check_word("t6_w0", 0, 0, {64{8'h5A}}, 1'b0);
    check_word("t6_flush", 0, 1, DW'(16'h5A5A), 1'b1);
    end_frame();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
